prt_port_arbiter: RTL

PRT_PORT_ARBITER -- requirements
Module: prt_port_arbiter

---
 rtl/prt_port_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/prt_port_arbiter.sv
// PRT port arbiter: clears a 1-bit-per-entry table through a single BRAM port,
// then shares that port between lookup reads and update writes with round-robin.
module prt_port_arbiter #(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned RD_LAT         = 2,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_req_addr,
  output logic              rd_rsp_valid,
  output logic              rd_rsp_data,
  output logic [ADDR_W-1:0] rd_rsp_addr,
  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic              wr_req_data,
  input  logic              init_start,
  output logic              init_busy,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_din,
  input  logic              bram_dout
);

  localparam int unsigned DEPTH = RD_LAT + 1;

  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] sweep_cnt;
  logic              last_wr;
  logic              we_q;
  logic              din_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DEPTH-1:0]  pipe_v;
  logic [ADDR_W-1:0] pipe_a [DEPTH];
  logic              rd_grant;
  logic              wr_grant;

  // Grants exclude rst so the reset net only gates outputs, never flop data.
  always_comb begin
    rd_grant = (state == RUN) && rd_req_valid && (!wr_req_valid || last_wr);
    wr_grant = (state == RUN) && wr_req_valid && (!rd_req_valid || !last_wr);
  end

  assign rd_req_ready = rd_grant && !rst;
  assign wr_req_ready = wr_grant && !rst;
  assign init_busy    = (state == INIT) && !rst;
  assign bram_we      = we_q;
  assign bram_addr    = addr_q;
  assign bram_din     = din_q;
  assign rd_rsp_valid = pipe_v[DEPTH-1];
  assign rd_rsp_addr  = pipe_a[DEPTH-1];
  assign rd_rsp_data  = bram_dout && pipe_v[DEPTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLEAR_ON_RESET ? INIT : RUN;
      sweep_cnt <= '0;
      last_wr   <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= 1'b0;
      pipe_v    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) pipe_a[i] <= '0;
    end else begin
      // Stage 0 is loaded at the accept edge; the last stage lines up with bram_dout.
      pipe_v[0] <= rd_grant;
      pipe_a[0] <= rd_req_addr;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_a[i] <= pipe_a[i-1];
      end
      unique case (state)
        INIT: begin
          we_q      <= 1'b1;
          addr_q    <= sweep_cnt;
          din_q     <= 1'b0;
          sweep_cnt <= sweep_cnt + ADDR_W'(1);
          if (sweep_cnt == '1) state <= RUN;
        end
        RUN: begin
          we_q <= wr_grant;
          if (wr_grant) begin
            addr_q  <= wr_req_addr;
            din_q   <= wr_req_data;
            last_wr <= 1'b1;
          end else if (rd_grant) begin
            addr_q  <= rd_req_addr;
            last_wr <= 1'b0;
          end
          if (init_start) state <= INIT;
        end
      endcase
    end
  end

endmodule
